fios_res_collector: RTL and testbench

Receives the word-serial result stream leaving the last PE of the FIOS Montgomery multiplier, least-significant word first. It reassembles the full `s`-word result and applies the final Montgomery conditional subtraction (`R >= p ? R - p : R`) word-serially while the words arrive. It presents the reduced result on a parallel bus through a valid/ready handshake. The block sits between the multiplier's `RES_o` and the consumer of the modular product.

---
 rtl/fios_pkg.sv | 27 ++
 rtl/word_sub_borrow.sv | 24 ++
 rtl/fios_res_collector.sv | 185 ++++++++++++++++++
 tb/tb_fios_res_collector.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fios_pkg.sv
// Shared definitions for the FIOS Montgomery datapath: result-collector
// state encoding and the one-word subtract-with-borrow used by the result
// collector and the operand serializer.
package fios_pkg;

    // Widest word the shared subtract helper supports; callers zero-extend
    // their operands to this width and take back only the bits they need.
    localparam int WORD_SUB_MAX_W = 64;

    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } res_col_state_t;

    // Returns {borrow_out, diff} for a - b - borrow_in.
    // Operands are zero-extended W-bit words (W < WORD_SUB_MAX_W), so the true
    // result lies in [-(2^W), 2^W - 1]. Bits W..WORD_SUB_MAX_W are therefore
    // all copies of the sign, and the top bit is the borrow out of bit W-1.
    function automatic logic [WORD_SUB_MAX_W:0] word_sub(
        input logic [WORD_SUB_MAX_W-1:0] a,
        input logic [WORD_SUB_MAX_W-1:0] b,
        input logic                      borrow_in
    );
        return {1'b0, a} - {1'b0, b} - {{WORD_SUB_MAX_W{1'b0}}, borrow_in};
    endfunction

endpackage

// File: rtl/word_sub_borrow.sv
// One word of a multi-word subtraction with borrow in and borrow out.
// Purely combinational wrapper around the shared word_sub helper.
module word_sub_borrow #(
    parameter int WORD_WIDTH = 17
) (
    input  logic [WORD_WIDTH-1:0] i_a,
    input  logic [WORD_WIDTH-1:0] i_b,
    input  logic                  i_borrow,
    output logic [WORD_WIDTH-1:0] o_diff,
    output logic                  o_borrow
);
    import fios_pkg::*;

    logic [WORD_SUB_MAX_W:0] w_full;
    logic                    w_unused_sign_bits;

    assign w_full   = word_sub(WORD_SUB_MAX_W'(i_a), WORD_SUB_MAX_W'(i_b), i_borrow);
    assign o_diff   = w_full[WORD_WIDTH-1:0];
    assign o_borrow = w_full[WORD_SUB_MAX_W];

    // The bits between the word and the borrow only repeat the sign.
    assign w_unused_sign_bits = ^w_full[WORD_SUB_MAX_W-1:WORD_WIDTH];

endmodule

// File: rtl/fios_res_collector.sv
// Collects the LSW-first word stream from the last FIOS PE, performs the
// final Montgomery conditional subtraction word-serially as words arrive
// (R and R - p are built side by side), and presents the reduced result on
// a parallel valid/ready output. A completed result that cannot be handed
// over is parked (PENDING); words arriving meanwhile are dropped and flagged.
module fios_res_collector #(
    parameter int WORD_WIDTH = 17,
    parameter int s          = 8
) (
    input  logic                       clock_i,
    input  logic                       reset_n_i,
    input  logic                       res_valid_i,
    input  logic [WORD_WIDTH-1:0]      res_i,
    input  logic [s*WORD_WIDTH-1:0]    p_i,
    output logic [s*WORD_WIDTH-1:0]    result_o,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic                       overflow_o
);
    import fios_pkg::*;

    localparam int TOTAL_W = s * WORD_WIDTH;
    localparam int IDX_W   = (s > 1) ? $clog2(s) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(s - 1);

    // State
    res_col_state_t           r_state;
    res_col_state_t           w_state_next;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_borrow;
    logic [TOTAL_W-1:0]       r_r;
    logic [TOTAL_W-1:0]       r_d;

    // Datapath wires
    logic [WORD_WIDTH-1:0]    w_p_words [s];
    logic [WORD_WIDTH-1:0]    w_p_word;
    logic                     w_borrow_in;
    logic [WORD_WIDTH-1:0]    w_diff;
    logic                     w_bout;
    logic [TOTAL_W-1:0]       w_r_shift;
    logic [TOTAL_W-1:0]       w_d_shift;
    logic [TOTAL_W-1:0]       w_load_value;

    // Control wires
    logic                     w_last;
    logic                     w_slot_free;
    logic                     w_accept;
    logic                     w_complete_load;
    logic                     w_pending_load;
    logic                     w_drop;
    logic                     w_load;

    // Split the modulus into words so the current word is a plain s-way select.
    genvar gi;
    generate
        for (gi = 0; gi < s; gi++) begin : g_p_word
            assign w_p_words[gi] = p_i[gi*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    assign w_p_word    = w_p_words[r_idx];
    assign w_borrow_in = (r_idx == '0) ? 1'b0 : r_borrow;

    word_sub_borrow #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_word_sub (
        .i_a      (res_i),
        .i_b      (w_p_word),
        .i_borrow (w_borrow_in),
        .o_diff   (w_diff),
        .o_borrow (w_bout)
    );

    // Words enter at the MSW end so that after s words word 0 sits at the LSW.
    assign w_r_shift = {res_i,  r_r[TOTAL_W-1:WORD_WIDTH]};
    assign w_d_shift = {w_diff, r_d[TOTAL_W-1:WORD_WIDTH]};

    assign w_last      = (r_idx == LAST_IDX);
    assign w_slot_free = !result_valid_o || result_ready_i;

    // FSM state register
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: park a finished result when the output slot is busy
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: begin
                if (res_valid_i && w_last && !w_slot_free) begin
                    w_state_next = PENDING;
                end
            end
            PENDING: begin
                if (result_ready_i) begin
                    w_state_next = COLLECT;
                end
            end
            default: w_state_next = COLLECT;
        endcase
    end

    // FSM outputs: word acceptance, result loads and drop detection
    always_comb begin
        w_accept        = 1'b0;
        w_complete_load = 1'b0;
        w_pending_load  = 1'b0;
        w_drop          = 1'b0;
        case (r_state)
            COLLECT: begin
                w_accept        = res_valid_i;
                w_complete_load = res_valid_i && w_last && w_slot_free;
            end
            PENDING: begin
                w_pending_load  = result_ready_i;
                w_drop          = res_valid_i;
            end
            default: ;
        endcase
    end

    assign w_load = w_complete_load || w_pending_load;

    // Final borrow clear means R >= p, so the difference is the reduced value.
    // A parked result takes its final borrow from r_borrow, which was frozen.
    always_comb begin
        w_load_value = '0;
        if (w_complete_load) begin
            w_load_value = w_bout ? w_r_shift : w_d_shift;
        end else begin
            w_load_value = r_borrow ? r_r : r_d;
        end
    end

    // Collection: shift R and D, carry the borrow, advance the word index
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_r      <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
        end else begin
            if (w_accept) begin
                r_r      <= w_r_shift;
                r_d      <= w_d_shift;
                r_borrow <= w_bout;
                if (!w_last) begin
                    r_idx <= r_idx + 1'b1;
                end else if (w_slot_free) begin
                    r_idx <= '0;
                end
            end else if (w_pending_load) begin
                r_idx <= '0;
            end
        end
    end

    // Output register: load on completion or release, clear on a bare handshake
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            result_o       <= '0;
            result_valid_o <= 1'b0;
        end else if (w_load) begin
            result_o       <= w_load_value;
            result_valid_o <= 1'b1;
        end else if (result_valid_o && result_ready_i) begin
            result_valid_o <= 1'b0;
        end
    end

    // Sticky drop flag
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            overflow_o <= 1'b0;
        end else if (w_drop) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fios_res_collector.sv
// Bench for fios_res_collector with 4-bit words, 2 words per result and
// modulus 0xB7: directed vector table, hand-written stall/overflow/reset
// sequences, and a randomized stream compared against R mod p.
module tb_fios_res_collector;

    localparam int W = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           res_valid = 1'b0;
    logic [W-1:0]   res = '0;
    logic [S*W-1:0] p = 8'hB7;
    logic [S*W-1:0] result;
    logic           result_valid;
    logic           ready = 1'b0;
    logic           overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic mon_en = 1'b0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [3:0] w0;
        logic [3:0] w1;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [3];

    fios_res_collector #(
        .WORD_WIDTH (W),
        .s          (S)
    ) dut (
        .clock_i        (clk),
        .reset_n_i      (rst_n),
        .res_valid_i    (res_valid),
        .res_i          (res),
        .p_i            (p),
        .result_o       (result),
        .result_valid_o (result_valid),
        .result_ready_i (ready),
        .overflow_o     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%02h", name, act);
        end
    endtask

    task automatic send_word(input logic [3:0] w);
        res_valid = 1'b1;
        res = w;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        res = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Random-phase monitor: with ready held high, every cycle that shows
    // result_valid is a distinct delivered result.
    always @(negedge clk) begin
        if (mon_en && result_valid && ready) begin
            if (exp_q.size() == 0) begin
                check("rand unexpected result", result, 8'hxx);
            end else begin
                check("rand result", result, exp_q.pop_front());
            end
        end
    end

    initial begin
        int unsigned r;
        logic [7:0] rb;
        int budget;

        vecs[0] = '{w0: 4'h0, w1: 4'hC, exp: 8'h09};
        vecs[1] = '{w0: 4'h0, w1: 4'h5, exp: 8'h50};
        vecs[2] = '{w0: 4'h7, w1: 4'hB, exp: 8'h00};

        // Reset state
        idle(2);
        check("reset result", result, 8'h00);
        check("reset valid", 8'(result_valid), 8'h00);
        check("reset overflow", 8'(overflow), 8'h00);
        rst_n = 1'b1;
        idle(1);

        // Directed vectors, consumer always ready
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_word(vecs[i].w0);
            check($sformatf("vec%0d valid after w0", i), 8'(result_valid), 8'h00);
            send_word(vecs[i].w1);
            check($sformatf("vec%0d valid", i), 8'(result_valid), 8'h01);
            check($sformatf("vec%0d result", i), result, vecs[i].exp);
            idle(1);
            check($sformatf("vec%0d valid cleared", i), 8'(result_valid), 8'h00);
        end

        // Stalled consumer: second result parks, fifth word is dropped
        ready = 1'b0;
        send_word(4'h0);
        send_word(4'hC);
        check("stall first valid", 8'(result_valid), 8'h01);
        check("stall first result", result, 8'h09);
        send_word(4'h0);
        send_word(4'h5);
        check("stall result held", result, 8'h09);
        check("stall no overflow yet", 8'(overflow), 8'h00);
        send_word(4'h3);
        check("stall overflow set", 8'(overflow), 8'h01);
        check("stall result after drop", result, 8'h09);
        ready = 1'b1;
        idle(1);
        check("release valid", 8'(result_valid), 8'h01);
        check("release result", result, 8'h50);
        idle(1);
        check("release cleared", 8'(result_valid), 8'h00);
        send_word(4'h7);
        send_word(4'hB);
        check("after release result", result, 8'h00);
        check("after release valid", 8'(result_valid), 8'h01);
        idle(1);

        // Handshake and completion on the same edge keep valid high
        ready = 1'b0;
        send_word(4'h0);
        send_word(4'hC);
        check("same-edge first", result, 8'h09);
        send_word(4'h0);
        ready = 1'b1;
        send_word(4'h5);
        check("same-edge valid", 8'(result_valid), 8'h01);
        check("same-edge result", result, 8'h50);
        check("overflow sticky", 8'(overflow), 8'h01);
        idle(1);
        check("same-edge cleared", 8'(result_valid), 8'h00);

        // Reset mid-stream discards the partial word
        send_word(4'h3);
        rst_n = 1'b0;
        idle(1);
        check("midreset overflow", 8'(overflow), 8'h00);
        check("midreset valid", 8'(result_valid), 8'h00);
        rst_n = 1'b1;
        idle(1);
        send_word(4'h0);
        send_word(4'hC);
        check("post-reset result", result, 8'h09);
        check("post-reset overflow", 8'(overflow), 8'h00);
        idle(1);

        // Randomized stream with gaps, consumer always ready
        mon_en = 1'b1;
        for (int k = 0; k < 50; k++) begin
            r = $urandom_range(0, 255);
            rb = r[7:0];
            exp_q.push_back(8'(r % 32'hB7));
            send_word(rb[3:0]);
            idle($urandom_range(0, 2));
            send_word(rb[7:4]);
            idle($urandom_range(0, 2));
        end
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        check("rand drained", 8'(exp_q.size()), 8'h00);
        check("rand overflow", 8'(overflow), 8'h00);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
